// File: rtl/vpg_mode_sequencer.sv
// Video-mode change sequencer: debounced button -> blank generator -> new mode -> PLL strobe -> relock/settle.
// Optional direct mode load (mode_sel/mode_load ports) is enabled by defining VPG_SEQ_DIRECT_MODE_EN.
module vpg_mode_sequencer #(
  parameter int NUM_MODES    = 5,
  parameter int INIT_MODE    = 0,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int BLANK_CYC    = 1024,
  parameter int UNLOCK_WAIT  = 4096,
  parameter int LOCK_TIMEOUT = 5000000,
  parameter int SETTLE_CYC   = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn_n,
  input  logic       pll_locked,
`ifdef VPG_SEQ_DIRECT_MODE_EN
  input  logic [3:0] mode_sel,
  input  logic       mode_load,
`endif
  output logic [3:0] mode,
  output logic       mode_change,
  output logic       gen_enable,
  output logic       busy,
  output logic       fault
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TIMER_MAX = max2(max2(BLANK_CYC, UNLOCK_WAIT), max2(LOCK_TIMEOUT, SETTLE_CYC));
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int DW        = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW        = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_BLANK,
    S_REQ,
    S_WAIT_UNLOCK,
    S_WAIT_LOCK,
    S_SETTLE,
    S_FAULT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic   [TW-1:0] timer;
  logic   [DW-1:0] db_cnt;
  logic   [RW-1:0] retry;
  logic   [1:0]    btn_sync;
  logic   [1:0]    lock_sync;
  logic            btn_s;
  logic            lock_s;
  logic            db_val;
  logic            db_done;
  logic            press;
  logic            pending;
  logic            pend_clr;
  logic            mode_upd;
  logic            retry_inc;
  logic            retry_clr;
  logic            timed;
  logic   [3:0]    mode_inc;
  logic   [3:0]    mode_new;

  assign btn_s  = btn_sync[1];
  assign lock_s = lock_sync[1];

  // Debounced value only moves after DEBOUNCE_CYC consecutive samples disagreeing with it.
  assign db_done = (btn_s != db_val) && (db_cnt == DW'(DEBOUNCE_CYC - 1));
  assign press   = db_done && !btn_s;

  assign mode_inc = (mode == 4'(NUM_MODES - 1)) ? 4'd0 : mode + 4'd1;
  assign timed    = (state == S_BLANK) || (state == S_WAIT_UNLOCK) ||
                    (state == S_WAIT_LOCK) || (state == S_SETTLE);

`ifdef VPG_SEQ_DIRECT_MODE_EN
  logic       load_ok;
  logic       load_start;
  logic       sel_load;
  logic [3:0] sel_code;

  assign load_ok  = mode_load && ({1'b0, mode_sel} < 5'(NUM_MODES)) && (mode_sel != mode);
  assign mode_new = sel_load ? sel_code : mode_inc;
  assign pend_clr = mode_upd && !sel_load;

  // A direct load remembers its target so the BLANK exit can apply it instead of incrementing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_load <= 1'b0;
      sel_code <= 4'd0;
    end else if (load_start) begin
      sel_load <= 1'b1;
      sel_code <= mode_sel;
    end else if (mode_upd) begin
      sel_load <= 1'b0;
    end
  end
`else
  assign mode_new = mode_inc;
  assign pend_clr = mode_upd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync  <= 2'b11;
      lock_sync <= 2'b00;
      db_val    <= 1'b1;
      db_cnt    <= '0;
    end else begin
      btn_sync  <= {btn_sync[0], mode_btn_n};
      lock_sync <= {lock_sync[0], pll_locked};
      if (btn_s == db_val) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_val <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT_LOCK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mode_upd   = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
`ifdef VPG_SEQ_DIRECT_MODE_EN
    load_start = 1'b0;
`endif
    case (state)
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
`ifdef VPG_SEQ_DIRECT_MODE_EN
        end else if (load_ok) begin
          state_next = S_BLANK;
          load_start = 1'b1;
`endif
        end else if (pending) begin
          state_next = S_BLANK;
        end
      end
      S_BLANK: begin
        if (timer == TW'(BLANK_CYC - 1)) begin
          state_next = S_REQ;
          mode_upd   = 1'b1;
        end
      end
      S_REQ: state_next = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: begin
        // A PLL that never reports loss of lock is tolerated by the timeout.
        if (!lock_s || (timer == TW'(UNLOCK_WAIT - 1))) begin
          state_next = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_SETTLE;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          retry_inc  = 1'b1;
          state_next = (int'(retry) + 1 < MAX_RETRY) ? S_REQ : S_FAULT;
        end
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
        end else if (timer == TW'(SETTLE_CYC - 1)) begin
          state_next = S_RUN;
          retry_clr  = 1'b1;
        end
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_WAIT_LOCK;
    endcase
  end

  // Outputs are registered from the next state so gen_enable (a reset_n downstream) never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= '0;
      retry       <= '0;
      pending     <= 1'b0;
      mode        <= 4'(INIT_MODE);
      mode_change <= 1'b0;
      gen_enable  <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
    end else begin
      if (state_next != state) begin
        timer <= '0;
      end else if (timed) begin
        timer <= timer + 1'b1;
      end
      if (retry_clr) begin
        retry <= '0;
      end else if (retry_inc) begin
        retry <= retry + 1'b1;
      end
      if (pend_clr) begin
        pending <= 1'b0;
      end else if (press && (state != S_FAULT)) begin
        pending <= 1'b1;
      end
      if (mode_upd) begin
        mode <= mode_new;
      end
      mode_change <= (state_next == S_REQ);
      gen_enable  <= (state_next == S_RUN);
      busy        <= (state_next != S_RUN);
      fault       <= fault | (state_next == S_FAULT);
    end
  end

endmodule
